// File: rtl/mul_arb_pkg.sv
// Shared sizing for the multiplier arbiter: default requester count and operand
// width, the id-width helper and the product-width constant.
package mul_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int PW_DEF   = 2 * W_DEF;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int id_width(input int nreq);
    int r;
    r = $clog2(nreq);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// Combinational round-robin pick: scans upward from ptr+1 with wrap and returns
// the first requesting index as one-hot, binary index and an any-grant flag.
module mul_rr_pick
  import mul_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  int              w_cand;
  logic [NREQ-1:0] w_shift;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_cand  = 0;
    w_shift = '0;
    // Offsets 1..NREQ visit every index once, ending on ptr itself.
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = int'(ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      w_shift = req_valid >> w_cand;
      if (!gnt_any && w_shift[0]) begin
        gnt_any = 1'b1;
        gnt_idx = w_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    for (int n = 0; n < NREQ; n++) begin
      gnt_onehot[n] = gnt_any && (int'(gnt_idx) == n);
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one unsigned W x W multiplier between NREQ requesters.
// Define MUL_ARBITER_PIPE_EN to add an operand register stage (latency 2 instead of 1).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int W    = W_DEF,
  localparam int IDW  = id_width(NREQ),
  localparam int PW   = prod_width(W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PW-1:0]     res_data,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  // Handshake: a word moves on a rising edge where valid and ready are both high.
  // Producers hold valid and payload until that edge; ready never looks at payload,
  // and a stage may load on the same edge its current contents move on.

  logic [IDW-1:0]  r_ptr;
  logic            r_res_valid;
  logic [PW-1:0]   r_res_data;
  logic [IDW-1:0]  r_res_id;

  logic [NREQ-1:0] w_gnt_onehot;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_gnt_any;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_out_load;
  logic            w_accept;
  logic [W-1:0]    w_mul_a;
  logic [W-1:0]    w_mul_b;
  logic [IDW-1:0]  w_mul_id;
  logic            w_mul_valid;
  logic [PW-1:0]   w_prod;

  mul_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_valid  (req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .gnt_any    (w_gnt_any)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (w_gnt_onehot[n]) begin
        w_sel_a = req_a[n*W +: W];
        w_sel_b = req_b[n*W +: W];
      end
    end
  end

  assign w_out_load = !r_res_valid || res_ready;

`ifdef MUL_ARBITER_PIPE_EN
  logic           r_s1_valid;
  logic [W-1:0]   r_s1_a;
  logic [W-1:0]   r_s1_b;
  logic [IDW-1:0] r_s1_id;
  logic           w_s1_load;

  // The operand stage frees up whenever its entry advances into the output stage.
  assign w_s1_load = !r_s1_valid || w_out_load;
  assign w_accept  = rst_n && w_gnt_any && w_s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a  <= w_sel_a;
        r_s1_b  <= w_sel_b;
        r_s1_id <= w_gnt_idx;
      end
    end
  end

  assign w_mul_a     = r_s1_a;
  assign w_mul_b     = r_s1_b;
  assign w_mul_id    = r_s1_id;
  assign w_mul_valid = r_s1_valid;
  assign busy        = r_res_valid || r_s1_valid;
`else
  assign w_accept    = rst_n && w_gnt_any && w_out_load;
  assign w_mul_a     = w_sel_a;
  assign w_mul_b     = w_sel_b;
  assign w_mul_id    = w_gnt_idx;
  assign w_mul_valid = w_accept;
  assign busy        = r_res_valid;
`endif

  assign w_prod    = PW'(w_mul_a) * PW'(w_mul_b);
  assign req_ready = w_accept ? w_gnt_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_gnt_idx;
    end
  end

  // Output stage holds its word until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else if (w_out_load) begin
      r_res_valid <= w_mul_valid;
      if (w_mul_valid) begin
        r_res_data <= w_prod;
        r_res_id   <= w_mul_id;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed grant orders and products.
module tb_mul_arbiter;
  import mul_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = id_width(NREQ);
  localparam int PW   = 2 * W;
  localparam int RW   = IDW + PW;
`ifdef MUL_ARBITER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [PW-1:0]     res_data;
  logic [IDW-1:0]    res_id;
  logic              busy;

  mul_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight results in acceptance order; each becomes visible LAT-1 cycles
  // after its accept edge and leaves when the consumer takes it.
  logic [RW-1:0]   exp_q[$];
  int              vis_q[$];
  int              mdl_ptr = NREQ - 1;
  logic            m_acc;
  logic            m_drain;
  int              m_idx;
  logic [PW-1:0]   m_prod;

  initial begin
    logic            ev;
    logic [RW-1:0]   head;
    logic [NREQ-1:0] m_ready;
    logic [W-1:0]    ma;
    logic [W-1:0]    mb;
    int              j;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_data", 32'(res_data), 32'(0));
        chk("rst_res_id", 32'(res_id), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        m_acc   = 1'b0;
        m_drain = 1'b0;
      end else begin
        ev = 1'b0;
        if (exp_q.size() > 0) begin
          if (vis_q[0] <= cyc) ev = 1'b1;
        end
        chk("res_valid", 32'(res_valid), 32'(ev));
        if (ev) begin
          head = exp_q[0];
          chk("res_data", 32'(res_data), 32'(head[PW-1:0]));
          chk("res_id", 32'(res_id), 32'(head[RW-1:PW]));
        end
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
        m_drain = ev && res_ready;
        m_idx = -1;
        for (int k = 1; k <= NREQ; k++) begin
          j = (mdl_ptr + k) % NREQ;
          if (m_idx < 0 && (|(req_valid & (NREQ'(1) << j)))) m_idx = j;
        end
        m_acc = (m_idx >= 0) && ((exp_q.size() - (m_drain ? 1 : 0)) < LAT);
        m_ready = m_acc ? (NREQ'(1) << m_idx) : '0;
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        if (m_acc) begin
          ma = W'(req_a >> (m_idx * W));
          mb = W'(req_b >> (m_idx * W));
          m_prod = PW'(ma) * PW'(mb);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        vis_q.delete();
        mdl_ptr = NREQ - 1;
      end else begin
        if (m_drain) begin
          void'(exp_q.pop_front());
          void'(vis_q.pop_front());
        end
        if (m_acc) begin
          exp_q.push_back({IDW'(m_idx), m_prod});
          vis_q.push_back(cyc + LAT);
          mdl_ptr = m_idx;
        end
      end
      cyc++;
    end
  end

  // ---------------- driver ----------------
  logic [W-1:0] pa_q [NREQ][$];
  logic [W-1:0] pb_q [NREQ][$];
  int grant_q[$];
  int obs_id[$];
  int obs_data[$];
  int obs_cyc[$];

  task automatic load_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (pa_q[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_a[i*W +: W]   = pa_q[i][0];
        req_b[i*W +: W]   = pb_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic offer(input int i, input int a, input int b);
    pa_q[i].push_back(W'(a));
    pb_q[i].push_back(W'(b));
    load_inputs();
  endtask

  task automatic clear_offers();
    for (int i = 0; i < NREQ; i++) begin
      pa_q[i].delete();
      pb_q[i].delete();
    end
    load_inputs();
  endtask

  task automatic clear_logs();
    grant_q.delete();
    obs_id.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  // One clock: sample both handshakes mid-cycle, then retire accepted pairs after the edge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (res_valid && res_ready) begin
      obs_id.push_back(int'(res_id));
      obs_data.push_back(int'(res_data));
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        void'(pa_q[i].pop_front());
        void'(pb_q[i].pop_front());
        grant_q.push_back(i);
      end
    end
    load_inputs();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_gnt(input string tag, input int idx, input int id);
    if (idx >= grant_q.size()) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: grant %0d missing, expected requester %0d", tag, idx, id);
    end else begin
      chk(tag, 32'(grant_q[idx]), 32'(id));
    end
  endtask

  task automatic chk_obs(input string tag, input int idx, input int id, input int data);
    if (idx >= obs_id.size()) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: result %0d missing, expected id %0d data 0x%0h", tag, idx, id, data);
    end else begin
      chk({tag, "_id"}, 32'(obs_id[idx]), 32'(id));
      chk({tag, "_data"}, 32'(obs_data[idx]), 32'(data));
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int k;
    rst_n     = 1'b0;
    res_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_req_ready", 32'(req_ready), 32'(0));
    chk("init_res_valid", 32'(res_valid), 32'(0));
    chk("init_busy", 32'(busy), 32'(0));
    clear_offers();
    rst_n = 1'b1;

    // Fairness: all four requesting, requester 0 twice.
    clear_logs();
    offer(0, 3, 5);
    offer(0, 7, 9);
    offer(1, 10, 20);
    offer(2, 255, 1);
    offer(3, 16, 16);
    steps(10);
    chk_gnt("fair_g0", 0, 0);
    chk_gnt("fair_g1", 1, 1);
    chk_gnt("fair_g2", 2, 2);
    chk_gnt("fair_g3", 3, 3);
    chk_gnt("fair_g4", 4, 0);
    chk_obs("fair_r0", 0, 0, 15);
    chk_obs("fair_r1", 1, 1, 200);
    chk_obs("fair_r2", 2, 2, 255);
    chk_obs("fair_r3", 3, 3, 256);
    chk_obs("fair_r4", 4, 0, 63);

    // Arithmetic corners from requester 2 alone.
    clear_logs();
    offer(2, 255, 255);
    offer(2, 0, 77);
    steps(6);
    chk_obs("arith_max", 0, 2, 16'hFE01);
    chk_obs("arith_zero", 1, 2, 0);
    if (obs_cyc.size() >= 2) chk("arith_back_to_back", 32'(obs_cyc[1] - obs_cyc[0]), 32'(1));
    else chk("arith_result_count", 32'(obs_cyc.size()), 32'(2));

    // Backpressure: consumer stalls for five cycles.
    clear_logs();
    res_ready = 1'b0;
    offer(1, 12, 10);
    offer(1, 12, 10);
    offer(3, 12, 10);
    offer(3, 12, 10);
    steps(5);
    chk("bp_accepts_while_full", 32'(grant_q.size()), 32'(LAT));
    chk("bp_no_drain", 32'(obs_id.size()), 32'(0));
    chk("bp_hold_valid", 32'(res_valid), 32'(1));
    chk("bp_hold_data", 32'(res_data), 32'(120));
    chk("bp_hold_id", 32'(res_id), 32'(3));
    res_ready = 1'b1;
    steps(8);
    chk("bp_result_count", 32'(obs_id.size()), 32'(4));
    chk_obs("bp_r0", 0, 3, 120);
    chk_obs("bp_r1", 1, 1, 120);
    chk_obs("bp_r2", 2, 3, 120);
    chk_obs("bp_r3", 3, 1, 120);
    for (int i = 1; i < obs_cyc.size(); i++)
      chk("bp_no_bubble", 32'(obs_cyc[i] - obs_cyc[i-1]), 32'(1));

    // Pointer holds across idle cycles.
    clear_logs();
    offer(1, 2, 3);
    steps(4);
    offer(0, 4, 4);
    offer(2, 5, 5);
    steps(6);
    chk_gnt("hold_g0", 0, 1);
    chk_gnt("hold_g1", 1, 2);
    chk_gnt("hold_g2", 2, 0);
    chk_obs("hold_r0", 0, 1, 6);
    chk_obs("hold_r1", 1, 2, 25);
    chk_obs("hold_r2", 2, 0, 16);

    // Reset with results in flight.
    clear_logs();
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      offer(i, i + 1, 3);
      offer(i, i + 2, 3);
    end
    steps(3);
    chk("mid_busy_before_reset", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res_valid", 32'(res_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
    clear_offers();
    steps(2);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    clear_logs();
    offer(1, 2, 2);
    offer(2, 3, 3);
    offer(0, 9, 9);
    steps(6);
    chk_gnt("post_rst_g0", 0, 0);
    chk_gnt("post_rst_g1", 1, 1);
    chk_gnt("post_rst_g2", 2, 2);
    chk_obs("post_rst_r0", 0, 0, 81);

    // Drain with a bounded wait.
    k = 0;
    while (busy && k < 50) begin
      step();
      k++;
    end
    chk("final_idle", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
